// File: rtl/pixel_array_pkg.sv
// Shared state type, default sizing constants and Gray-code helpers for pixel_array_ctrl.
// The Gray helpers are only referenced when PIXEL_ARRAY_GRAY_EN is defined.
package pixel_array_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READOUT
    } state_t;

    localparam int DEF_N_PIX     = 4;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_ERASE_CYC = 5;
    localparam int MAX_CNT_W     = 12;

    function automatic logic [MAX_CNT_W-1:0] bin_to_gray(input logic [MAX_CNT_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_CNT_W-1:0] gray_to_bin(input logic [MAX_CNT_W-1:0] g);
        logic [MAX_CNT_W-1:0] b;
        b[MAX_CNT_W-1] = g[MAX_CNT_W-1];
        for (int i = MAX_CNT_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_code_latch.sv
// Per-channel code store: captures the ramp code on the first comparator trip of a frame.
// A channel still untripped on the final ramp value takes that value, i.e. saturates.
module pixel_code_latch
    import pixel_array_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             capture_en,
    input  logic             last,
    input  logic             cmp,
    input  logic [CNT_W-1:0] code_in,
    output logic [CNT_W-1:0] code
);

    logic tripped;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tripped <= 1'b0;
            code    <= '0;
        end else if (clear) begin
            tripped <= 1'b0;
            code    <= '0;
        end else if (capture_en && !tripped && (!cmp || last)) begin
            tripped <= 1'b1;
            code    <= code_in;
        end
    end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Ramp-ADC pixel array sequencer: ERASE/EXPOSE/CONVERT phases, shared ramp counter and
// valid/ready readout of per-pixel codes. Optional macro: PIXEL_ARRAY_GRAY_EN (Gray-coded ramp).
module pixel_array_ctrl
    import pixel_array_pkg::*;
#(
    parameter  int N_PIX     = DEF_N_PIX,
    parameter  int CNT_W     = DEF_CNT_W,
    parameter  int ERASE_CYC = DEF_ERASE_CYC,
    localparam int IDX_W     = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             START,
    input  logic [15:0]      EXPOSE_TIME,
    input  logic [N_PIX-1:0] CMP,
    output logic             ERASE,
    output logic             EXPOSE,
    output logic             CONVERT,
    output logic [CNT_W-1:0] RAMP_CNT,
    output logic [CNT_W-1:0] DOUT,
    output logic [IDX_W-1:0] DOUT_IDX,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    localparam logic [CNT_W-1:0] RAMP_LAST = '1;

    state_t           state;
    logic [15:0]      phase_cnt;
    logic [15:0]      expose_len;
    logic [CNT_W-1:0] ramp;
    logic [CNT_W-1:0] ramp_next_enc;
    logic [CNT_W-1:0] dout_code;
    logic [CNT_W-1:0] store [N_PIX];
    logic             clear_codes;
    logic             ramp_last;

    // Codes are wiped on the same edge that enters CONVERT, so the first ramp value can be captured.
    assign clear_codes = (state == S_EXPOSE) && (phase_cnt == expose_len - 16'd1);
    assign ramp_last   = (ramp == RAMP_LAST);

`ifdef PIXEL_ARRAY_GRAY_EN
    logic [MAX_CNT_W-1:0] ramp_next_wide;
    logic [MAX_CNT_W-1:0] dout_wide;
    assign ramp_next_wide = bin_to_gray(MAX_CNT_W'(ramp + CNT_W'(1)));
    assign ramp_next_enc  = ramp_next_wide[CNT_W-1:0];
    assign dout_wide      = gray_to_bin(MAX_CNT_W'(store[DOUT_IDX]));
    assign dout_code      = dout_wide[CNT_W-1:0];
`else
    assign ramp_next_enc  = ramp + CNT_W'(1);
    assign dout_code      = store[DOUT_IDX];
`endif

    assign DOUT = DOUT_VALID ? dout_code : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            expose_len <= 16'd1;
            ramp       <= '0;
            RAMP_CNT   <= '0;
            ERASE      <= 1'b0;
            EXPOSE     <= 1'b0;
            CONVERT    <= 1'b0;
            DOUT_IDX   <= '0;
            DOUT_VALID <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        expose_len <= (EXPOSE_TIME == 16'd0) ? 16'd1 : EXPOSE_TIME;
                        phase_cnt  <= '0;
                        ERASE      <= 1'b1;
                        BUSY       <= 1'b1;
                        state      <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    if (phase_cnt == 16'(ERASE_CYC - 1)) begin
                        phase_cnt <= '0;
                        ERASE     <= 1'b0;
                        EXPOSE    <= 1'b1;
                        state     <= S_EXPOSE;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_EXPOSE: begin
                    if (clear_codes) begin
                        phase_cnt <= '0;
                        EXPOSE    <= 1'b0;
                        CONVERT   <= 1'b1;
                        ramp      <= '0;
                        RAMP_CNT  <= '0;
                        state     <= S_CONVERT;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                S_CONVERT: begin
                    if (ramp_last) begin
                        CONVERT    <= 1'b0;
                        ramp       <= '0;
                        RAMP_CNT   <= '0;
                        DOUT_IDX   <= '0;
                        DOUT_VALID <= 1'b1;
                        state      <= S_READOUT;
                    end else begin
                        ramp     <= ramp + CNT_W'(1);
                        RAMP_CNT <= ramp_next_enc;
                    end
                end
                S_READOUT: begin
                    if (DOUT_READY) begin
                        if (DOUT_IDX == IDX_W'(N_PIX - 1)) begin
                            DOUT_VALID <= 1'b0;
                            DOUT_IDX   <= '0;
                            FRAME_DONE <= 1'b1;
                            BUSY       <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            DOUT_IDX <= DOUT_IDX + IDX_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_PIX; i++) begin : g_pix
        pixel_code_latch #(.CNT_W(CNT_W)) u_latch (
            .clk        (clk),
            .reset_n    (reset_n),
            .clear      (clear_codes),
            .capture_en (CONVERT),
            .last       (ramp_last),
            .cmp        (CMP[i]),
            .code_in    (RAMP_CNT),
            .code       (store[i])
        );
    end

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Parametrised digital sequencer and readout engine for an N-pixel ramp-ADC sensor array. It drives the array's ERASE/EXPOSE/CONVERT phases and generates the shared ramp counter. It captures each pixel's counter code when that pixel's comparator trips, then streams the codes out one pixel at a time over a valid/ready interface. It sits between the analog pixel array and the frame-capture logic, and replaces fixed per-pixel READ strobes with an internal per-pixel code store.

## Interface
- N_PIX, 4, number of pixels/comparator channels (1..64)
- CNT_W, 8, ramp counter and pixel code width (4..12)
- ERASE_CYC, 5, cycles ERASE is held high (>=1)
- clk  input  1  sole clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- START  input  1  frame request, sampled in IDLE only
- EXPOSE_TIME  input  16  exposure length in cycles, sampled with START; 0 treated as 1
- CMP  input  N_PIX  pixel comparator outputs; high while ramp below pixel voltage; synchronous to clk, no internal synchroniser
- ERASE  output  1  pixel erase phase
- EXPOSE  output  1  pixel expose phase
- CONVERT  output  1  ramp conversion phase
- RAMP_CNT  output  CNT_W  counter to ramp DAC
- DOUT  output  CNT_W  pixel code
- DOUT_IDX  output  $clog2(N_PIX) (min 1)  pixel index of DOUT
- DOUT_VALID  output  1  DOUT/DOUT_IDX valid
- DOUT_READY  input  1  sink accepts
- BUSY  output  1  high in any state but IDLE
- FRAME_DONE  output  1  one-cycle pulse after last pixel accepted

## Operation
- Reset: state IDLE; all outputs 0; code store and captured flags cleared; phase counter 0.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> READOUT -> IDLE.
- IDLE: START=1 latches EXPOSE_TIME, goes to ERASE. START in any other state is ignored.
- ERASE: ERASE=1 for exactly ERASE_CYC cycles.
- EXPOSE: EXPOSE=1 for max(EXPOSE_TIME,1) cycles.
- CONVERT: CONVERT=1, RAMP_CNT steps 0,1,...,2^CNT_W-1, one value per cycle. Captured flags and store are cleared on CONVERT entry.
- Capture: in a CONVERT cycle where CMP[i]=0 and flag i is clear, store[i]<=RAMP_CNT and set flag i. Only the first trip per frame counts; later toggles are ignored.
- Simultaneous trips on several channels in one cycle: all capture the same code.
- Channels never tripped by the last ramp value: store all-ones (saturated).
- RAMP_CNT returns to 0 on leaving CONVERT.
- READOUT: DOUT_IDX starts at 0 with DOUT_VALID=1 and DOUT=store[DOUT_IDX]. DOUT, DOUT_IDX and DOUT_VALID stay stable until DOUT_VALID&DOUT_READY. On handshake, the index increments.
- After index N_PIX-1 is accepted: DOUT_VALID=0, FRAME_DONE=1 for one cycle, return to IDLE.
- reset_n low in any state aborts the frame immediately to the reset values; no FRAME_DONE.

## Timing
- START high at edge k: ERASE=1, BUSY=1 from edge k (registered outputs, visible after edge k).
- All phase outputs are registered, with exactly one phase high at a time and no gap cycles between phases.
- A CMP trip sampled at edge m while RAMP_CNT=v stores v (code of the same cycle, no offset).
- The cycle after the final ramp value: DOUT_VALID=1, idx 0.
- With DOUT_READY held high: one pixel per cycle.
- FRAME_DONE coincides with the first IDLE cycle. START is accepted again in that same cycle.
- Frame length with READY=1: ERASE_CYC + max(EXPOSE_TIME,1) + 2^CNT_W + N_PIX cycles, plus FRAME_DONE.

## Configuration
- PIXEL_ARRAY_GRAY_EN defined:
  - RAMP_CNT carries the Gray code of the internal binary count.
  - Capture stores the Gray value.
  - DOUT is Gray-to-binary converted, so DOUT values are identical to the non-Gray build.
- Undefined: RAMP_CNT is plain binary and no conversion logic is present.

## Structure
- Package pixel_array_pkg holds:
  - the state enum (IDLE, ERASE, EXPOSE, CONVERT, READOUT);
  - default parameter constants;
  - Gray encode/decode functions.
- Sub-module pixel_code_latch (one per channel, generate loop) holds the flag, CNT_W register, first-trip capture and saturation fill.

## Test plan
- N_PIX=4, CNT_W=8, EXPOSE_TIME=10, CMP[i] drops at RAMP_CNT=51,102,153,204, READY=1 -> DOUT 51,102,153,204 on idx 0..3, FRAME_DONE once.
- CMP[2] never drops -> DOUT idx2 = 255. CMP[0] toggles 0/1/0 after first trip -> code of the first trip only.
- READY low for 3 cycles on idx1 -> DOUT/IDX stable throughout; idx advances only on handshake.
- EXPOSE_TIME=0 -> EXPOSE high exactly 1 cycle. START pulses during EXPOSE -> no effect, single frame.
- reset_n low mid-CONVERT -> all outputs 0 immediately. New START after release -> full correct frame, no stale codes.
- PIXEL_ARRAY_GRAY_EN defined -> RAMP_CNT shows Gray sequence 0,1,3,2,...; DOUT values match the binary build for the first scenario.
